// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: MULT/DIV 33 cycles of busy after the accept edge, done pulses the cycle after; MTHI/MTLO visible next cycle.
// Backpressure: start is sampled only while idle; the pipeline stalls on busy; flush aborts in-flight work with no done.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic             is_div;   // latched op class: 1 = divide, 0 = multiply
    logic             neg_q;    // negate product / quotient in FIX
    logic             rneg;     // negate remainder in FIX (sign of dividend)
    logic             dz;       // divisor was zero
    logic [WIDTH-1:0] opnd;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / dividend shifting into quotient

    // Operand conditioning at accept: signs only count for the signed ops.
    logic             signed_op;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    // One shared iteration step, selected by op class.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // Sign correction results written in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign busy = (state != IDLE);

    // Magnitudes and result signs of the incoming operands.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        s1        = signed_op & data1[WIDTH-1];
        s2        = signed_op & data2[WIDTH-1];
        mag1      = s1 ? (~data1 + 1'b1) : data1;
        mag2      = s2 ? (~data2 + 1'b1) : data2;
    end

    // Iteration datapath: shift-add multiply (LSB first) or restoring divide (MSB first).
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_rs  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge  = (div_rs >= {1'b0, opnd});
        // Only used when div_ge, where the true difference is below opnd and fits in WIDTH bits.
        div_sub = div_rs[WIDTH-1:0] - opnd;
        if (is_div) begin
            next_hi = div_ge ? div_sub : div_rs[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Final sign fix-up; divide-by-zero yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        quo    = neg_q ? (~acc_lo + 1'b1) : acc_lo;
        rem    = rneg ? (~acc_hi + 1'b1) : acc_hi;
        if (is_div) begin
            fix_hi = rem;
            fix_lo = dz ? {WIDTH{1'b1}} : quo;
        end else begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration registers and HI/LO updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            rneg   <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    is_div <= op[1];
                                    neg_q  <= s1 ^ s2;
                                    rneg   <= s1;
                                    dz     <= (data2 == '0);
                                    opnd   <= op[1] ? mag2 : mag1;
                                    acc_lo <= op[1] ? mag1 : mag2;
                                    acc_hi <= '0;
                                    cnt    <= 5'd0;
                                    state  <= RUN;
                                end
                                OP_MTHI: begin
                                    hi   <= data1;
                                    done <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo   <= data1;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    RUN: begin
                        acc_hi <= next_hi;
                        acc_lo <= next_lo;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random operations against an arithmetic HI/LO model.
// Latency: checks 33 busy cycles for MULT/DIV and immediate update for MTHI/MTLO.
// Backpressure: exercises start-while-busy, flush, back-to-back start and asynchronous reset.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert;
    int n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .data1 (data1),
        .data2 (data2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge and follow it to its done cycle; returns at the done negedge.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit pester);
        int  cyc;
        bit  iter;
        iter  = (o <= 3'd3);
        start = 1'b1;
        op    = o;
        data1 = a;
        data2 = b;
        model(o, a, b);
        @(negedge clk);
        // operands may change after accept; a start here must be ignored while busy
        start = pester & iter;
        op    = 3'd1;
        data1 = $urandom;
        data2 = $urandom;
        if (iter) chk({tag, "_done_low"}, {31'b0, done}, 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, cyc, iter ? 32'd33 : 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        data1    = 32'd0;
        data2    = 32'd0;
        flush    = 1'b0;

        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed arithmetic cases, issued back to back on each done cycle
        do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("mult_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("divu", 3'd3, 32'd100, 32'd7, 1'b0);
        do_op("divu_z", 3'd3, 32'd100, 32'd0, 1'b0);
        do_op("div_z", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);
        do_op("mthi", 3'd4, 32'h1234, 32'd0, 1'b0);
        @(negedge clk);
        chk("mthi_done_fall", {31'b0, done}, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        // flush during a divide
        start = 1'b1; op = 3'd2; data1 = 32'd1000; data2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_hi", hi, 32'h1234);
        @(negedge clk);
        chk("flush_done2", {31'b0, done}, 32'd0);

        // flush in idle suppresses start
        start = 1'b1; op = 3'd5; data1 = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_lo", lo, m_lo);
        chk("flush_idle_done", {31'b0, done}, 32'd0);

        // reserved op is ignored
        start = 1'b1; op = 3'd6; data1 = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("op6_busy", {31'b0, busy}, 32'd0);
        chk("op6_done", {31'b0, done}, 32'd0);
        chk("op6_hi", hi, m_hi);
        chk("op6_lo", lo, m_lo);

        // random operations
        for (int i = 0; i < 30; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 5));
            do_op($sformatf("rnd%0d", i), ro, pick(), pick(), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd0; data1 = 32'h7FFF_0001; data2 = 32'h0001_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_busy", {31'b0, busy}, 32'd0);
        chk("amid_done", {31'b0, done}, 32'd0);
        chk("amid_hi", hi, 32'd0);
        chk("amid_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst", 3'd0, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        chk("post_rst_done_fall", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
